// File: rtl/gpu_vga_pkg.sv
// Shared raster timing presets, polarity constants and helpers for the scan-out timing generator.
package gpu_vga_pkg;

  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA480_H_ACTIVE = 640;
  localparam int VGA480_H_FP     = 16;
  localparam int VGA480_H_SYNC   = 96;
  localparam int VGA480_H_BP     = 48;
  localparam int VGA480_V_ACTIVE = 480;
  localparam int VGA480_V_FP     = 10;
  localparam int VGA480_V_SYNC   = 2;
  localparam int VGA480_V_BP     = 33;
  localparam bit VGA480_HS_POS   = POL_NEG;
  localparam bit VGA480_VS_POS   = POL_NEG;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA600_H_ACTIVE = 800;
  localparam int SVGA600_H_FP     = 40;
  localparam int SVGA600_H_SYNC   = 128;
  localparam int SVGA600_H_BP     = 88;
  localparam int SVGA600_V_ACTIVE = 600;
  localparam int SVGA600_V_FP     = 1;
  localparam int SVGA600_V_SYNC   = 4;
  localparam int SVGA600_V_BP     = 23;
  localparam bit SVGA600_HS_POS   = POL_POS;
  localparam bit SVGA600_VS_POS   = POL_POS;

  function automatic int tim_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(int active, int fp, int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int H_TOTAL = tim_total(VGA480_H_ACTIVE, VGA480_H_FP, VGA480_H_SYNC, VGA480_H_BP);
  localparam int V_TOTAL = tim_total(VGA480_V_ACTIVE, VGA480_V_FP, VGA480_V_SYNC, VGA480_V_BP);
  localparam int H_SYNC_START = sync_start(VGA480_H_ACTIVE, VGA480_H_FP);
  localparam int H_SYNC_END   = sync_end(VGA480_H_ACTIVE, VGA480_H_FP, VGA480_H_SYNC);
  localparam int V_SYNC_START = sync_start(VGA480_V_ACTIVE, VGA480_V_FP);
  localparam int V_SYNC_END   = sync_end(VGA480_V_ACTIVE, VGA480_V_FP, VGA480_V_SYNC);

  // Display-side flags, always active-high internally; polarity is applied at the pins.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic line;
    logic frame;
  } disp_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH = 0 is a plain wire with no storage.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clock, reset_n, en};
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;

    always_comb begin
      sr_d = sr_q;
      if (en) begin
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sr_q <= '0;
      else          sr_q <= sr_d;
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator and framebuffer address sequencer: fetch-side counters lead the
// display-side sync/enable outputs by FETCH_LAT pixel ticks to cover RAM read latency.
module vga_timing_gen
  import gpu_vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA480_H_ACTIVE,
  parameter int H_FP      = VGA480_H_FP,
  parameter int H_SYNC    = VGA480_H_SYNC,
  parameter int H_BP      = VGA480_H_BP,
  parameter int V_ACTIVE  = VGA480_V_ACTIVE,
  parameter int V_FP      = VGA480_V_FP,
  parameter int V_SYNC    = VGA480_V_SYNC,
  parameter int V_BP      = VGA480_V_BP,
  parameter bit HS_POS    = VGA480_HS_POS,
  parameter bit VS_POS    = VGA480_VS_POS,
  parameter int CLK_DIV   = 1,
  parameter int SCALE     = 0,
  parameter int FETCH_LAT = 2,
  parameter int ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] FB_BASE0 = '0,
  parameter logic [ADDR_W-1:0] FB_BASE1 = {1'b1, {(ADDR_W-1){1'b0}}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              fb_sel,
  output logic              hsync,
  output logic              vsync,
  output logic              buffer_enable,
  output logic [ADDR_W-1:0] fbuffer_addr,
  output logic              pixel_tick,
  output logic              line_start,
  output logic              frame_start
);

  localparam int HT    = tim_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT    = tim_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_ST = sync_start(H_ACTIVE, H_FP);
  localparam int HS_EN = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_ST = sync_start(V_ACTIVE, V_FP);
  localparam int VS_EN = sync_end(V_ACTIVE, V_FP, V_SYNC);
  localparam int HW    = $clog2(HT);
  localparam int VW    = $clog2(VT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SMASK = (1 << SCALE) - 1;
  localparam int ROW_STEP = H_ACTIVE >> SCALE;

  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     fx_q, fx_d;
  logic [VW-1:0]     fy_q, fy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic fb_sel_q, fb_sel_d, swap_ack_q, swap_ack_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, be_q, be_d;
  logic pixel_tick_q, pixel_tick_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic tick, line_end, frame_end, fetch_vis;
  disp_flags_t fetch_flags, disp_flags;

  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign line_end  = (fx_q == HW'(HT - 1));
  assign frame_end = line_end && (fy_q == VW'(VT - 1));
  assign fetch_vis = (fx_q < HW'(H_ACTIVE)) && (fy_q < VW'(V_ACTIVE));

  assign fetch_flags.act   = fetch_vis;
  assign fetch_flags.hs    = (fx_q >= HW'(HS_ST)) && (fx_q <= HW'(HS_EN));
  assign fetch_flags.vs    = (fy_q >= VW'(VS_ST)) && (fy_q <= VW'(VS_EN));
  assign fetch_flags.line  = (fx_q == '0);
  assign fetch_flags.frame = (fx_q == '0) && (fy_q == '0);

  vga_delay_line #(
    .WIDTH($bits(disp_flags_t)),
    .DEPTH(FETCH_LAT)
  ) u_dly (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (tick),
    .d      (fetch_flags),
    .q      (disp_flags)
  );

  always_comb begin
    div_d         = tick ? '0 : div_q + DW'(1);
    fx_d          = fx_q;
    fy_d          = fy_q;
    row_base_d    = row_base_q;
    addr_d        = addr_q;
    fb_sel_d      = fb_sel_q;
    swap_ack_d    = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    be_d          = be_q;
    pixel_tick_d  = tick;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      fx_d = line_end ? '0 : fx_q + HW'(1);
      if (line_end) begin
        fy_d = frame_end ? '0 : fy_q + VW'(1);
        // Advance one source row only after the last replicated display line of it.
        if (frame_end)
          row_base_d = '0;
        else if (fy_q < VW'(V_ACTIVE) && (fy_q & VW'(SMASK)) == VW'(SMASK))
          row_base_d = row_base_q + ADDR_W'(ROW_STEP);
      end
      if (fetch_vis)
        addr_d = (fb_sel_q ? FB_BASE1 : FB_BASE0) + row_base_q + ADDR_W'(fx_q >> SCALE);
      if (frame_end && swap_req) begin
        fb_sel_d   = ~fb_sel_q;
        swap_ack_d = 1'b1;
      end
      hsync_d       = disp_flags.hs ~^ HS_POS;
      vsync_d       = disp_flags.vs ~^ VS_POS;
      be_d          = disp_flags.act;
      line_start_d  = disp_flags.line;
      frame_start_d = disp_flags.frame;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      fx_q          <= '0;
      fy_q          <= '0;
      row_base_q    <= '0;
      addr_q        <= FB_BASE0;
      fb_sel_q      <= 1'b0;
      swap_ack_q    <= 1'b0;
      hsync_q       <= ~HS_POS;
      vsync_q       <= ~VS_POS;
      be_q          <= 1'b0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      row_base_q    <= row_base_d;
      addr_q        <= addr_d;
      fb_sel_q      <= fb_sel_d;
      swap_ack_q    <= swap_ack_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      be_q          <= be_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign swap_ack      = swap_ack_q;
  assign fb_sel        = fb_sel_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign buffer_enable = be_q;
  assign fbuffer_addr  = addr_q;
  assign pixel_tick    = pixel_tick_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;

endmodule
